// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read-port and valid/ready stream signals handled by fifo_stream_reader.
// The master view belongs to the reader; the slave view belongs to the FIFO and the consumer.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_empty;
  logic             flush;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic             busy;

  modport master (
    output fifo_rd_en, m_valid, m_data, busy,
    input  fifo_rd_data, fifo_empty, flush, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, busy,
    output fifo_rd_data, fifo_empty, flush, m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle read latency into a valid/ready stream,
// using a 3-entry holding buffer so that back-to-back words can be delivered every cycle.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
);

  logic [1:0]       occ_q, occ_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf_q [3];
  logic [WIDTH-1:0] buf_d [3];

  logic [2:0] pending;
  logic       rd_en;
  logic       capture;
  logic       pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    buf_d      = buf_q;
    // Reserving a slot for the in-flight word keeps the buffer from ever overflowing.
    pending    = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_en      = rst_n & ~bus.flush & ~bus.fifo_empty & (pending < 3'd3);
    inflight_d = rd_en;
    capture    = inflight_q;
    pop        = (occ_q != 2'd0) & bus.m_ready;

    if (bus.flush) begin
      occ_d  = 2'd0;
      head_d = 2'd0;
      tail_d = 2'd0;
    end else begin
      if (capture) begin
        buf_d[tail_q] = bus.fifo_rd_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      occ_d = occ_q + {1'b0, capture} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      inflight_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = buf_q[head_q];
  assign bus.busy       = (occ_q != 2'd0) | inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural FIFO with registered read data feeds the DUT,
// a cycle-table covers latency/empty boundaries, and hand sequences cover reset, streaming,
// backpressure, flush and random ready.
module tb_fifo_stream_reader;

  logic clk;
  logic rst_n;

  fifo_stream_reader_if #(.WIDTH(8)) bus ();

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         npush;
    logic [7:0] v0;
    logic [7:0] v1;
    logic       rdy;
    logic       e_rd;
    logic       e_val;
    logic [7:0] e_dat;
    logic       chk_dat;
    logic       e_busy;
  } row_t;

  int         n_checks;
  int         n_err;
  int         beats;
  int         rd_pulses;
  logic [7:0] mem   [$];
  logic [7:0] exp_q [$];
  logic       stall_prev;
  logic [7:0] stall_data;
  row_t       tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem.push_back(v);
    exp_q = exp_q;
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: observe the cycle before the edge, then let the FIFO model respond after it.
  task automatic tick();
    logic       en;
    logic       fl;
    logic       rs;
    logic [7:0] w;
    @(negedge clk);
    en = bus.fifo_rd_en;
    fl = bus.flush;
    rs = rst_n;
    check("rden_while_empty", 32'(en & bus.fifo_empty), 32'd0);
    if (stall_prev) begin
      check("hold_valid", 32'(bus.m_valid), 32'd1);
      check("hold_data", 32'(bus.m_data), 32'(stall_data));
    end
    if (rs && !fl && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("beat_extra", 32'(bus.m_data), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("beat_data", 32'(bus.m_data), 32'(w));
      end
      beats++;
    end
    stall_prev = rs & ~fl & bus.m_valid & ~bus.m_ready;
    stall_data = bus.m_data;
    if (en) rd_pulses++;
    @(posedge clk);
    #1;
    if (!rs || fl) exp_q.delete();
    if (en) begin
      w = mem.pop_front();
      bus.fifo_rd_data = w;
      exp_q.push_back(w);
    end
    bus.fifo_empty = (mem.size() == 0);
    check("occ_bound", 32'(exp_q.size() <= 3), 32'd1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_err = 0;
    beats = 0;
    rd_pulses = 0;
    stall_prev = 1'b0;
    stall_data = 8'h00;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.m_ready = 1'b0;
    bus.fifo_rd_data = 8'h00;
    bus.fifo_empty = 1'b1;

    // Reset with a non-empty FIFO, then streaming 0x01..0x10.
    for (int i = 1; i <= 16; i++) push(8'(i));
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check("rst_valid", 32'(bus.m_valid), 32'd0);
      check("rst_data", 32'(bus.m_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("first_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      check($sformatf("stream_valid_k%0d", k), 32'(bus.m_valid), 32'((k >= 2) && (k < 18)));
      tick();
    end
    check("stream_beats", 32'(beats), 32'd16);
    check("stream_pulses", 32'(rd_pulses), 32'd16);

    // Cycle table from a fresh reset: single word 0xA5, then a two-word burst with a stall.
    bus.m_ready = 1'b0;
    do_reset();
    tbl[0] = '{1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1};
    tbl[3] = '{2, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};
    tbl[6] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};
    tbl[7] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
    tbl[8] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    rd_pulses = 0;
    beats = 0;
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].npush >= 1) push(tbl[r].v0);
      if (tbl[r].npush >= 2) push(tbl[r].v1);
      bus.m_ready = tbl[r].rdy;
      #1;
      check($sformatf("tbl%0d_rd_en", r), 32'(bus.fifo_rd_en), 32'(tbl[r].e_rd));
      check($sformatf("tbl%0d_valid", r), 32'(bus.m_valid), 32'(tbl[r].e_val));
      if (tbl[r].chk_dat) check($sformatf("tbl%0d_data", r), 32'(bus.m_data), 32'(tbl[r].e_dat));
      check($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].e_busy));
      tick();
    end
    check("tbl_pulses", 32'(rd_pulses), 32'd3);
    check("tbl_beats", 32'(beats), 32'd3);

    // Backpressure: 8 words, consumer stalled.
    bus.m_ready = 1'b0;
    rd_pulses = 0;
    beats = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int c = 0; c < 10; c++) tick();
    check("bp_pulses", 32'(rd_pulses), 32'd3);
    check("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_data", 32'(bus.m_data), 32'h01);
    check("bp_busy", 32'(bus.busy), 32'd1);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 40 && beats < 8; c++) tick();
    check("bp_beats", 32'(beats), 32'd8);
    check("bp_drained_valid", 32'(bus.m_valid), 32'd0);
    check("bp_drained_busy", 32'(bus.busy), 32'd0);

    // Flush with two words buffered and one in flight.
    bus.m_ready = 1'b0;
    rd_pulses = 0;
    beats = 0;
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
    for (int c = 0; c < 3; c++) tick();
    check("fl_pre_pulses", 32'(rd_pulses), 32'd3);
    check("fl_pre_valid", 32'(bus.m_valid), 32'd1);
    check("fl_pre_data", 32'(bus.m_data), 32'h31);
    check("fl_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("fl_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("fl_post_valid", 32'(bus.m_valid), 32'd0);
    check("fl_post_busy", 32'(bus.busy), 32'd0);
    check("fl_resume_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && beats < 2; c++) tick();
    check("fl_beats", 32'(beats), 32'd2);
    check("fl_pulses", 32'(rd_pulses), 32'd5);
    tick();
    check("fl_end_busy", 32'(bus.busy), 32'd0);

    // Random ready over 200 words.
    beats = 0;
    for (int j = 0; j < 200; j++) push(8'((j * 7 + 3) & 255));
    for (int c = 0; c < 3000 && beats < 200; c++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rand_beats", 32'(beats), 32'd200);
    bus.m_ready = 1'b1;
    tick();
    tick();
    check("rand_end_valid", 32'(bus.m_valid), 32'd0);
    check("rand_end_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
